// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM pin-group arbiter and its helpers.
package psram_pkg;

  // Arbiter states: bus free, bus owned, chip-select guard gap between owners.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } arb_state_t;

  // Requester slots on the arbiter.
  localparam int REQ_MFCC    = 0;
  localparam int REQ_CONV1   = 1;
  localparam int REQ_CONV2   = 2;
  localparam int REQ_FC1     = 3;
  localparam int REQ_FC2     = 4;
  localparam int REQ_MAXPOOL = 5;
  localparam int REQ_SOFTMAX = 6;

  // Pad values driven whenever nobody owns the bus.
  localparam logic       PSRAM_IDLE_SCK    = 1'b0;
  localparam logic       PSRAM_IDLE_CE_N   = 1'b1;
  localparam logic [3:0] PSRAM_IDLE_DOUTEN = 4'h0;
  localparam logic [3:0] PSRAM_IDLE_DOUT   = 4'h0;

endpackage

// File: rtl/psram_bus_arbiter_if.sv
// Requester-side handshake and pad-side signals of the PSRAM arbiter.
interface psram_bus_arbiter_if #(
  parameter int NUM_REQ = 7
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   rel;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   req_sck;
  logic [NUM_REQ-1:0]   req_ce_n;
  logic [4*NUM_REQ-1:0] req_douten;
  logic [4*NUM_REQ-1:0] req_dout;
  logic [3:0]           req_din;
  logic                 psram_sck;
  logic                 psram_ce_n;
  logic [3:0]           psram_douten;
  logic [3:0]           psram_dout;
  logic [3:0]           psram_din;

  // Arbiter view: consumes requests and requester pins, drives grants and pads.
  modport slave (
    input  req, rel, req_sck, req_ce_n, req_douten, req_dout, psram_din,
    output gnt, req_din, psram_sck, psram_ce_n, psram_douten, psram_dout
  );

  // Requester/pad-environment view.
  modport master (
    output req, rel, req_sck, req_ce_n, req_douten, req_dout, psram_din,
    input  gnt, req_din, psram_sck, psram_ce_n, psram_douten, psram_dout
  );
endinterface

// File: rtl/psram_bus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request strictly after ptr.
module rr_picker #(
  parameter int  NUM_REQ = 7,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               valid,
  output logic [IDW-1:0]     idx
);

  int             cand;
  logic [IDW-1:0] cand_idx;

  // Scan ptr+1, ptr+2, ... wrapping, and keep the first requester found.
  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(ptr) + i) % NUM_REQ;
      cand_idx = IDW'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/psram_bus_arbiter.sv
// Round-robin owner arbitration of the quad-SPI PSRAM pins with guard gap and watchdog.
module psram_bus_arbiter
  import psram_pkg::*;
#(
  parameter int  NUM_REQ        = 7,
  parameter int  GUARD_CYCLES   = 2,
  parameter int  TIMEOUT_CYCLES = 4096,
  localparam int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  psram_bus_arbiter_if.slave        bus,
  output logic                      busy,
  output logic [IDW-1:0]            owner_id,
  output logic                      timeout_err
);

  localparam logic [3:0]  GUARD_INIT = 4'(GUARD_CYCLES - 1);
  localparam logic [31:0] WDOG_LAST  = 32'(TIMEOUT_CYCLES - 1);

  arb_state_t         state;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IDW-1:0]     rr_ptr;
  logic [3:0]         guard_cnt;
  logic [31:0]        wdog_cnt;
  logic               pick_valid;
  logic [IDW-1:0]     pick_idx;
  logic               owner_rel;
  logic               owner_req;
  logic               wdog_hit;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_rel   = bus.rel[owner_id];
  assign owner_req   = bus.req[owner_id];
  assign wdog_hit    = (TIMEOUT_CYCLES != 0) && (wdog_cnt == WDOG_LAST);
  assign bus.gnt     = gnt_q;
  assign bus.req_din = bus.psram_din;
  assign busy        = (state != IDLE);

  // Ownership FSM: grant, hold until release/implicit release/watchdog, then guard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_q       <= '0;
      owner_id    <= '0;
      rr_ptr      <= IDW'(NUM_REQ - 1);
      guard_cnt   <= '0;
      wdog_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        GRANT: begin
          if (owner_rel || !owner_req || wdog_hit) begin
            state       <= GUARD;
            gnt_q       <= '0;
            guard_cnt   <= GUARD_INIT;
            wdog_cnt    <= '0;
            timeout_err <= wdog_hit && !owner_rel && owner_req;
          end else begin
            wdog_cnt <= wdog_cnt + 32'd1;
          end
        end
        default: begin
          if (state == GUARD && guard_cnt != 4'd0) begin
            guard_cnt <= guard_cnt - 4'd1;
          end else if (pick_valid) begin
            state    <= GRANT;
            gnt_q    <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            owner_id <= pick_idx;
            rr_ptr   <= pick_idx;
            wdog_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Pads follow the owner only while granted; idle values otherwise.
  always_comb begin
    bus.psram_sck    = PSRAM_IDLE_SCK;
    bus.psram_ce_n   = PSRAM_IDLE_CE_N;
    bus.psram_douten = PSRAM_IDLE_DOUTEN;
    bus.psram_dout   = PSRAM_IDLE_DOUT;
    if (state == GRANT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner_id == IDW'(i)) begin
          bus.psram_sck    = bus.req_sck[i];
          bus.psram_ce_n   = bus.req_ce_n[i];
          bus.psram_douten = bus.req_douten[4*i +: 4];
          bus.psram_dout   = bus.req_dout[4*i +: 4];
        end
      end
    end
  end

endmodule

// File: tb/tb_psram_bus_arbiter.sv
// Scoreboard bench for psram_bus_arbiter: grant order, pad muxing, guard gap, watchdog, reset.
module tb_psram_bus_arbiter;
  import psram_pkg::*;

  localparam int NUM_REQ        = 7;
  localparam int GUARD_CYCLES   = 2;
  localparam int TIMEOUT_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [2:0] owner_id;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  int high_run = 0;

  psram_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  psram_bus_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .GUARD_CYCLES   (GUARD_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .busy        (busy),
    .owner_id    (owner_id),
    .timeout_err (timeout_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] reqv, input logic [NUM_REQ-1:0] relv);
    bus.req = reqv;
    bus.rel = relv;
  endtask

  task automatic clearInputs();
    applyStimulus('0, '0);
    bus.req_sck    = '0;
    bus.req_ce_n   = '1;
    bus.req_douten = '0;
    bus.req_dout   = '0;
    bus.psram_din  = 4'h0;
  endtask

  // Advance to the next falling edge and track the run of ce_n-high cycles.
  task automatic tick();
    @(negedge clk);
    if (bus.psram_ce_n) high_run++;
    else high_run = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    clearInputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    high_run = 0;
  endtask

  // Wait (bounded) for a grant, then check it against the scoreboard head.
  task automatic waitGrant(output int waited, output int who);
    waited = 0;
    who    = 0;
    while (bus.gnt == '0 && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("grant_seen", 32'(bus.gnt != '0), 32'd1);
    if (exp_q.size() == 0) begin
      checkOutput("sb_unexpected_grant", 32'(bus.gnt), 32'd0);
    end else begin
      who = exp_q.pop_front();
      checkOutput("grant_onehot", 32'(bus.gnt), 32'd1 << who);
      checkOutput("owner_id", 32'(owner_id), 32'(who));
    end
  endtask

  initial begin
    int w;
    int who;
    clearInputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("rst_owner", 32'(owner_id), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_terr", 32'(timeout_err), 32'd0);
    checkOutput("rst_ce_n", 32'(bus.psram_ce_n), 32'd1);
    checkOutput("rst_sck", 32'(bus.psram_sck), 32'd0);
    checkOutput("rst_douten", 32'(bus.psram_douten), 32'd0);
    checkOutput("rst_dout", 32'(bus.psram_dout), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    $display("[TB] single requester");
    bus.req_ce_n[2]      = 1'b0;
    bus.req_sck[2]       = 1'b1;
    bus.req_douten[11:8] = 4'hF;
    bus.req_dout[11:8]   = 4'hA;
    bus.psram_din        = 4'h5;
    exp_q.push_back(REQ_CONV2);
    applyStimulus(7'b0000100, '0);
    waitGrant(w, who);
    checkOutput("grant_latency", 32'(w), 32'd1);
    checkOutput("own_ce_n", 32'(bus.psram_ce_n), 32'd0);
    checkOutput("own_sck", 32'(bus.psram_sck), 32'd1);
    checkOutput("own_douten", 32'(bus.psram_douten), 32'hF);
    checkOutput("own_dout", 32'(bus.psram_dout), 32'hA);
    checkOutput("own_busy", 32'(busy), 32'd1);
    checkOutput("din_bypass", 32'(bus.req_din), 32'h5);

    $display("[TB] non-owner release and drive");
    bus.req_ce_n[2]       = 1'b1;
    bus.req_sck[2]        = 1'b0;
    bus.req_ce_n[4]       = 1'b0;
    bus.req_sck[4]        = 1'b1;
    bus.req_douten[19:16] = 4'h3;
    applyStimulus(7'b0000100, 7'b0010000);
    tick();
    checkOutput("nonown_gnt", 32'(bus.gnt), 32'h04);
    checkOutput("nonown_ce_n", 32'(bus.psram_ce_n), 32'd1);
    checkOutput("nonown_sck", 32'(bus.psram_sck), 32'd0);
    checkOutput("nonown_douten", 32'(bus.psram_douten), 32'hF);
    bus.req_ce_n[4] = 1'b1;
    bus.req_sck[4]  = 1'b0;
    bus.req_ce_n[2] = 1'b0;

    $display("[TB] release and guard");
    applyStimulus(7'b0000000, 7'b0000100);
    tick();
    applyStimulus('0, '0);
    checkOutput("guard1_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("guard1_ce_n", 32'(bus.psram_ce_n), 32'd1);
    checkOutput("guard1_douten", 32'(bus.psram_douten), 32'd0);
    checkOutput("guard1_busy", 32'(busy), 32'd1);
    checkOutput("guard1_terr", 32'(timeout_err), 32'd0);
    tick();
    checkOutput("guard2_ce_n", 32'(bus.psram_ce_n), 32'd1);
    checkOutput("guard2_busy", 32'(busy), 32'd1);
    tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_ce_n", 32'(bus.psram_ce_n), 32'd1);
    checkOutput("idle_owner_kept", 32'(owner_id), 32'd2);

    $display("[TB] re-request");
    exp_q.push_back(REQ_CONV2);
    applyStimulus(7'b0000100, '0);
    waitGrant(w, who);
    exp_q.push_back(REQ_CONV2);
    applyStimulus(7'b0000100, 7'b0000100);
    tick();
    applyStimulus(7'b0000100, '0);
    checkOutput("rereq_guard_gnt", 32'(bus.gnt), 32'd0);
    waitGrant(w, who);
    checkOutput("rereq_latency", 32'(w), 32'd2);
    exp_q.push_back(REQ_FC2);
    exp_q.push_back(REQ_CONV2);
    applyStimulus(7'b0010100, '0);
    tick();
    applyStimulus(7'b0010100, 7'b0000100);
    tick();
    applyStimulus(7'b0010100, '0);
    waitGrant(w, who);
    applyStimulus(7'b0000100, '0);
    tick();
    waitGrant(w, who);
    applyStimulus('0, '0);
    repeat (4) tick();

    $display("[TB] round-robin fairness");
    doReset();
    for (int n = 0; n < 6; n++) exp_q.push_back(1 + 2 * (n % 3));
    applyStimulus(7'b0101010, '0);
    for (int n = 0; n < 6; n++) begin
      waitGrant(w, who);
      if (n > 0) checkOutput("rr_ce_gap", 32'(high_run), 32'd3);
      bus.req_ce_n[who] = 1'b0;
      repeat (4) tick();
      checkOutput("rr_hold_gnt", 32'(bus.gnt), 32'd1 << who);
      checkOutput("rr_hold_ce_n", 32'(bus.psram_ce_n), 32'd0);
      bus.req_ce_n[who] = 1'b1;
      bus.rel[who]      = 1'b1;
      if (n == 5) bus.req = '0;
      tick();
      bus.rel[who] = 1'b0;
      checkOutput("rr_rel_gnt", 32'(bus.gnt), 32'd0);
    end
    repeat (4) tick();

    $display("[TB] watchdog");
    doReset();
    exp_q.push_back(REQ_MFCC);
    exp_q.push_back(REQ_FC1);
    bus.req_ce_n[0]    = 1'b0;
    bus.req_douten[3:0] = 4'hF;
    applyStimulus(7'b0001001, '0);
    waitGrant(w, who);
    repeat (15) tick();
    checkOutput("wd_still_owned", 32'(bus.gnt), 32'h01);
    checkOutput("wd_no_err_yet", 32'(timeout_err), 32'd0);
    tick();
    applyStimulus(7'b0001000, '0);
    checkOutput("wd_revoked", 32'(bus.gnt), 32'd0);
    checkOutput("wd_terr", 32'(timeout_err), 32'd1);
    checkOutput("wd_ce_n_idle", 32'(bus.psram_ce_n), 32'd1);
    checkOutput("wd_douten_idle", 32'(bus.psram_douten), 32'd0);
    tick();
    checkOutput("wd_terr_pulse", 32'(timeout_err), 32'd0);
    waitGrant(w, who);
    checkOutput("wd_next_latency", 32'(w), 32'd1);
    repeat (15) tick();
    exp_q.push_back(REQ_FC1);
    applyStimulus(7'b0001000, 7'b0001000);
    tick();
    applyStimulus(7'b0001000, '0);
    checkOutput("relwd_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("relwd_no_terr", 32'(timeout_err), 32'd0);
    waitGrant(w, who);
    applyStimulus('0, '0);
    repeat (4) tick();

    $display("[TB] implicit release");
    doReset();
    exp_q.push_back(REQ_SOFTMAX);
    applyStimulus(7'b1000000, '0);
    waitGrant(w, who);
    repeat (2) tick();
    applyStimulus('0, '0);
    tick();
    checkOutput("impl_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("impl_busy", 32'(busy), 32'd1);
    checkOutput("impl_terr", 32'(timeout_err), 32'd0);
    repeat (2) tick();
    checkOutput("impl_idle", 32'(busy), 32'd0);

    $display("[TB] async reset mid-grant");
    exp_q.push_back(REQ_CONV2);
    bus.req_ce_n[2]      = 1'b0;
    bus.req_douten[11:8] = 4'hF;
    applyStimulus(7'b0000100, '0);
    waitGrant(w, who);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("arst_ce_n", 32'(bus.psram_ce_n), 32'd1);
    checkOutput("arst_douten", 32'(bus.psram_douten), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_owner", 32'(owner_id), 32'd0);
    clearInputs();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(REQ_MFCC);
    applyStimulus(7'b0100001, '0);
    waitGrant(w, who);
    checkOutput("arst_rr_latency", 32'(w), 32'd1);
    applyStimulus('0, '0);
    repeat (4) tick();

    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psram_bus_arbiter.md
Name: psram_bus_arbiter

Overview:
Arbitrates the single quad-SPI PSRAM pin group between the layer engines (conv1, conv2, fc1, fc2, maxpool, softmax) and the MFCC feature writer. Replaces state-based muxing of PSRAM signals with explicit req/gnt ownership, so engines can overlap compute with other engines' memory phases. Sits between the engine PSRAM ports and the top-level psram_sck / psram_ce_n / psram_d / psram_douten pins. Round-robin arbitration, ownership held until release, enforced chip-select guard gap, and a watchdog against hung owners.

Parameters:
NUM_REQ, 7, number of requesters; index 0 = MFCC, 1..6 = conv1, conv2, fc1, fc2, maxpool, softmax.
GUARD_CYCLES, 2, cycles psram_ce_n is forced high between owners; legal range 1..15.
TIMEOUT_CYCLES, 4096, maximum cycles of continuous ownership; 0 disables the watchdog.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester bus request, level
rel  in  NUM_REQ  per-requester release strobe; only the owner's bit is honoured
gnt  out  NUM_REQ  one-hot grant, registered
req_sck  in  NUM_REQ  requester SCK
req_ce_n  in  NUM_REQ  requester chip select, active low
req_douten  in  4*NUM_REQ  requester data output enables, requester i at [4i+3:4i]
req_dout  in  4*NUM_REQ  requester output data
req_din  out  4  pad input data, broadcast to all requesters
psram_sck  out  1  to pad
psram_ce_n  out  1  to pad
psram_douten  out  4  to pad output enables
psram_dout  out  4  to pad output data
psram_din  in  4  from pad input data
busy  out  1  high in GRANT or GUARD
owner_id  out  clog2(NUM_REQ)  index of current or last owner
timeout_err  out  1  one-cycle pulse when the watchdog revokes a grant

Behaviour:
- Reset (async on rst_n low): state IDLE, gnt=0, owner_id=0, rr pointer=NUM_REQ-1, busy=0, timeout_err=0, guard and watchdog counters 0. Pad outputs at idle values: sck=0, ce_n=1, douten=0, dout=0. Reset mid-transfer drops the grant immediately and idles the bus.
- States: IDLE, GRANT, GUARD.
- IDLE: if any req is high, pick the first requester at or after rr+1 (mod NUM_REQ). Next cycle: gnt[winner]=1, owner_id=winner, rr=winner, state GRANT, watchdog=0. Latency from req to gnt is 1 cycle.
- GRANT: pads combinationally follow the owner's req_* signals. Other requesters see nothing; their req is held pending.
- GRANT exit: rel[owner]=1, or req[owner]=0 (implicit release), or watchdog==TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES!=0. On exit: gnt=0 next cycle, state GUARD, guard counter=GUARD_CYCLES-1. Watchdog exit also pulses timeout_err for exactly 1 cycle. rel from non-owners is ignored.
- GUARD: pads held at idle values regardless of requester inputs. Counter decrements each cycle. At 0, arbitrate exactly as in IDLE (grant next cycle if any req high), otherwise go to IDLE. Minimum ce_n-high gap between owners is GUARD_CYCLES+1 cycles.
- Re-request: an owner that releases and still requests loses to any other pending requester (rr has advanced). If it is the sole requester, it is re-granted after the guard.
- Simultaneous rel and timeout in the same cycle: treat as a normal release, with no timeout_err.
- req_din = psram_din always. No registering, no gating.
- gnt is registered and one-hot or zero. Pad mux is combinational on owner_id and state, so there are no glitch-sensitive paths on gnt.
- busy = (state != IDLE).

Decomposition:
- Shared package psram_pkg: arb_state_t enum (IDLE, GRANT, GUARD), requester index localparams (REQ_MFCC=0 … REQ_SOFTMAX=6), PSRAM idle pin values.
- One sub-module, rr_picker: a combinational round-robin priority encoder with inputs req vector and rr pointer, and outputs valid and index. It is reused later by the PSRAM write-back queue.

Test Plan:
- Single requester: req[2]=1 at cycle 10 -> gnt=7'b0000100 at cycle 11, psram_ce_n follows req_ce_n[2]. rel[2] at cycle 20 -> gnt=0 at 21, ce_n=1 for cycles 21–23 (GUARD_CYCLES=2).
- Round-robin fairness: req[1], req[3], req[5] held high continuously, each releasing after 5 cycles of ownership -> grant order 1,3,5,1,3,5, with a 3-cycle ce_n-high gap between each owner.
- Non-owner release and drive: rel[4]=1 and req_ce_n[4]=0 while 2 owns the bus -> no state change; pads still follow requester 2.
- Watchdog: TIMEOUT_CYCLES=16, owner 0 never releases -> gnt revoked 16 cycles after grant, timeout_err high for 1 cycle, pads idle, next pending requester granted after the guard.
- Implicit release: owner 6 drops req without rel -> GUARD entered next cycle, timeout_err=0.
- Async reset mid-GRANT: rst_n low between clock edges -> gnt=0, psram_ce_n=1, psram_douten=0 immediately. After release, req[0]=1 -> requester 0 granted (rr pointer reset to 6).
